// File: rtl/vsc_pkg.sv
// Shared types and constants for the vector sweep checker.
package vsc_pkg;

  localparam int unsigned VEC_W    = 5;
  localparam int unsigned NUM_VEC  = 32;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned ERR_W    = 6;
  localparam int unsigned GLITCH_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic s;
    logic a;
    logic b;
    logic c;
    logic d;
  } vec_t;

  // Vector index to selector inputs: {s,a,b,c,d} = idx[4:0].
  function automatic vec_t idx_to_vec(input logic [VEC_W-1:0] idx);
    return vec_t'(idx);
  endfunction

endpackage

// File: rtl/vector_sweep_checker_if.sv
// Stimulus/result bundle between the sweep checker and the selector under test.
// Carries glitch_count only when GLITCH_MON_EN is defined.
interface vector_sweep_checker_if;
  import vsc_pkg::*;

  logic                start;
  logic                o_in;
  logic                a;
  logic                b;
  logic                c;
  logic                d;
  logic                s;
  logic                busy;
  logic                done;
  logic                pass;
  logic [ERR_W-1:0]    err_count;
  logic [VEC_W-1:0]    first_err_idx;
  logic                first_err_vld;
`ifdef GLITCH_MON_EN
  logic [GLITCH_W-1:0] glitch_count;
`endif

  modport master (
    input  start, o_in,
    output a, b, c, d, s, busy, done, pass, err_count, first_err_idx, first_err_vld
`ifdef GLITCH_MON_EN
    , output glitch_count
`endif
  );

  modport slave (
    output start, o_in,
    input  a, b, c, d, s, busy, done, pass, err_count, first_err_idx, first_err_vld
`ifdef GLITCH_MON_EN
    , input glitch_count
`endif
  );

endinterface

// File: rtl/vsc_glitch_mon.sv
// Counts o_in transitions seen during settle windows (GLITCH_MON_EN builds only).
`ifdef GLITCH_MON_EN
module vsc_glitch_mon
  import vsc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic                o_in,
  output logic [GLITCH_W-1:0] glitch_count
);

  logic o_r;
  logic o_rr;

  // Two-deep history of o_in; counter saturates at all ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_r          <= 1'b0;
      o_rr         <= 1'b0;
      glitch_count <= '0;
    end else begin
      o_r  <= o_in;
      o_rr <= o_r;
      if (clr)
        glitch_count <= '0;
      else if (en && (o_r != o_rr) && (glitch_count != '1))
        glitch_count <= glitch_count + GLITCH_W'(1);
    end
  end

endmodule
`endif

// File: rtl/vector_sweep_checker.sv
// Sweeps all 32 selector input vectors, samples o after a settle window and
// compares against EXPECT. Define GLITCH_MON_EN to add a settle-window glitch counter.
module vector_sweep_checker
  import vsc_pkg::*;
#(
  parameter logic [31:0] EXPECT        = 32'h0000_0000,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  vector_sweep_checker_if.master  bus
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("vector_sweep_checker: SETTLE_CYCLES must be 1..255");
  end

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SETTLE = SETTLE;
  localparam logic [1:0] S_SAMPLE = SAMPLE;
  localparam logic [1:0] S_DONE   = DONE;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_IDX   = VEC_W'(NUM_VEC - 1);

  logic [1:0]       state_q, state_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [VEC_W-1:0] fidx_q, fidx_d;
  logic             fvld_q, fvld_d;
  logic             mism_c;
  logic [ERR_W-1:0] err_tot_c;
  vec_t             vec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fidx_q  <= '0;
      fvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fvld_q  <= fvld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    fidx_d    = fidx_q;
    fvld_d    = fvld_q;
    mism_c    = 1'b0;
    err_tot_c = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_SETTLE;
          idx_d   = '0;
          cnt_d   = CNT_RELOAD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fidx_d  = '0;
          fvld_d  = 1'b0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0)
          state_d = S_SAMPLE;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
      S_SAMPLE: begin
        // o_in is only trusted here, after the full settle window.
        mism_c    = (bus.o_in != EXPECT[idx_q]);
        err_tot_c = err_q + ERR_W'(mism_c);
        err_d     = err_tot_c;
        if (mism_c && !fvld_q) begin
          fidx_d = idx_q;
          fvld_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_tot_c == '0);
        end else begin
          state_d = S_SETTLE;
          idx_d   = idx_q + VEC_W'(1);
          cnt_d   = CNT_RELOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign vec               = idx_to_vec(idx_q);
  assign bus.s             = vec.s;
  assign bus.a             = vec.a;
  assign bus.b             = vec.b;
  assign bus.c             = vec.c;
  assign bus.d             = vec.d;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = fidx_q;
  assign bus.first_err_vld = fvld_q;

`ifdef GLITCH_MON_EN
  vsc_glitch_mon u_glitch_mon (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start),
    .en           (state_q == S_SETTLE),
    .o_in         (bus.o_in),
    .glitch_count (bus.glitch_count)
  );
`endif

endmodule

// File: tb/tb_vector_sweep_checker.sv
// Self-checking bench: table-driven sweeps, random truth tables vs a popcount model,
// reset abort, SETTLE_CYCLES=1 timing with start held, optional glitch counter.
module tb_vector_sweep_checker;
  import vsc_pkg::*;

  localparam logic [31:0] EXP = 32'hA5A5_0F0F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_sweep_checker_if if4();
  vector_sweep_checker_if if1();

  logic [31:0] tt4 = EXP;
  logic [31:0] tt1 = EXP;
  logic        glitch_mode = 1'b0;
  logic        glitch_o = 1'b0;

  assign if4.o_in = glitch_mode ? glitch_o : tt4[{if4.s, if4.a, if4.b, if4.c, if4.d}];
  assign if1.o_in = tt1[{if1.s, if1.a, if1.b, if1.c, if1.d}];

  vector_sweep_checker #(.EXPECT(EXP), .SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.master));
  vector_sweep_checker #(.EXPECT(EXP), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: mismatches are simply the bits where the DUT table differs from EXP.
  function automatic int ref_errs(input logic [31:0] tt);
    int n = 0;
    for (int i = 0; i < 32; i++) if (tt[i] != EXP[i]) n++;
    return n;
  endfunction

  function automatic int ref_first(input logic [31:0] tt);
    for (int i = 0; i < 32; i++) if (tt[i] != EXP[i]) return i;
    return -1;
  endfunction

  function automatic int vec4();
    return int'({if4.s, if4.a, if4.b, if4.c, if4.d});
  endfunction

  function automatic int vec1();
    return int'({if1.s, if1.a, if1.b, if1.c, if1.d});
  endfunction

  task automatic start4();
    @(negedge clk) if4.start = 1'b1;
    @(posedge clk) #1;
    if4.start = 1'b0;
  endtask

  task automatic wait_done4(output int cyc);
    cyc = 0;
    while (!if4.done && cyc < 400) begin
      @(posedge clk) #1;
      cyc++;
    end
  endtask

  task automatic sweep_and_check(input string tag, input int exp_err, input int exp_first);
    int cyc;
    start4();
    chk({tag, ".busy_at_start"}, int'(if4.busy), 1);
    wait_done4(cyc);
    chk({tag, ".done_latency"}, cyc, 160);
    chk({tag, ".err_count"}, int'(if4.err_count), exp_err);
    chk({tag, ".pass"}, int'(if4.pass), (exp_err == 0) ? 1 : 0);
    chk({tag, ".first_err_vld"}, int'(if4.first_err_vld), (exp_first >= 0) ? 1 : 0);
    chk({tag, ".first_err_idx"}, int'(if4.first_err_idx), (exp_first >= 0) ? exp_first : 0);
    chk({tag, ".busy_at_done"}, int'(if4.busy), 0);
    chk({tag, ".vec_at_done"}, vec4(), 31);
  endtask

  typedef struct {
    logic [31:0] tt;
    int          err;
    int          first;
  } vec_rec_t;

  vec_rec_t tbl[5];

  initial begin
    int cyc;
    logic [31:0] r;
    if4.start = 1'b0;
    if1.start = 1'b0;
    tbl[0] = '{EXP,                  0, -1};
    tbl[1] = '{32'h0000_0000,       16,  0};
    tbl[2] = '{32'hFFFF_FFFF,       16,  4};
    tbl[3] = '{EXP ^ 32'h8000_0000,  1, 31};
    tbl[4] = '{EXP ^ 32'h0000_0110,  2,  4};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", int'(if4.busy), 0);
    chk("rst.done", int'(if4.done), 0);
    chk("rst.pass", int'(if4.pass), 0);
    chk("rst.err_count", int'(if4.err_count), 0);
    chk("rst.first_vld", int'(if4.first_err_vld), 0);
    chk("rst.vec", vec4(), 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tt4 = tbl[i].tt;
      sweep_and_check($sformatf("tbl%0d", i), tbl[i].err, tbl[i].first);
`ifdef GLITCH_MON_EN
      if (tt4 == 32'h0 || tt4 == 32'hFFFF_FFFF)
        chk($sformatf("tbl%0d.glitch_count", i), int'(if4.glitch_count), 0);
`endif
    end

    for (int k = 0; k < 6; k++) begin
      r = $urandom;
      if (k == 0) r = EXP ^ (32'h1 << $urandom_range(31));
      tt4 = r;
      sweep_and_check($sformatf("rand%0d", k), ref_errs(r), ref_first(r));
    end

    // Abort mid-sweep with errors accumulated, then rerun clean.
    tt4 = 32'h0;
    start4();
    repeat (49) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk) #1;
    chk("abort.busy", int'(if4.busy), 0);
    chk("abort.done", int'(if4.done), 0);
    chk("abort.pass", int'(if4.pass), 0);
    chk("abort.err_count", int'(if4.err_count), 0);
    chk("abort.first_idx", int'(if4.first_err_idx), 0);
    chk("abort.first_vld", int'(if4.first_err_vld), 0);
    chk("abort.vec", vec4(), 0);
    @(negedge clk) rst_n = 1'b1;
    tt4 = EXP;
    sweep_and_check("restart", 0, -1);

    // SETTLE_CYCLES=1 with start held high for the whole sweep.
    @(negedge clk) if1.start = 1'b1;
    @(posedge clk) #1;
    for (int j = 0; j < 64; j++) begin
      chk($sformatf("s1.vec%0d", j), vec1(), j / 2);
      chk($sformatf("s1.busy%0d", j), int'(if1.busy), 1);
      @(posedge clk) #1;
    end
    chk("s1.done", int'(if1.done), 1);
    chk("s1.pass", int'(if1.pass), 1);
    chk("s1.err_count", int'(if1.err_count), 0);
    chk("s1.vec_done", vec1(), 31);
    @(posedge clk) #1;
    chk("s1.restart_done", int'(if1.done), 0);
    chk("s1.restart_busy", int'(if1.busy), 1);
    chk("s1.restart_vec", vec1(), 0);
    @(negedge clk) if1.start = 1'b0;

`ifdef GLITCH_MON_EN
    glitch_mode = 1'b1;
    glitch_o    = 1'b0;
    start4();
    chk("glitch.cleared", int'(if4.glitch_count), 0);
    cyc = 0;
    while (vec4() != 7 && cyc < 100) begin
      @(posedge clk) #1;
      cyc++;
    end
    chk("glitch.reach_vec7", vec4(), 7);
    glitch_o = ~glitch_o;
    @(posedge clk) #1 glitch_o = ~glitch_o;
    @(posedge clk) #1 glitch_o = ~glitch_o;
    wait_done4(cyc);
    chk("glitch.done", int'(if4.done), 1);
    chk("glitch.count3", int'(if4.glitch_count), 3);
    sweep_and_check("glitch_quiet", ref_errs(32'hFFFF_FFFF), ref_first(32'hFFFF_FFFF));
    chk("glitch.count0", int'(if4.glitch_count), 0);
    glitch_mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
